// File: rtl/if_fetch.sv
// Instruction fetch stage: issues one req/gnt/rvalid bus read per PC, delivers
// the word to decode through a 1-entry skid buffer, and flushes on jump.
module if_fetch #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter logic [DATA_W-1:0] NOP_INST = 32'h0000_0013
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc_in,
  input  logic              jump_flag_in,
  input  logic              hold_flag_in,
  output logic              hold_req_out,
  output logic              ibus_req_out,
  output logic [ADDR_W-1:0] ibus_addr_out,
  input  logic              ibus_gnt_in,
  input  logic              ibus_rvalid_in,
  input  logic [DATA_W-1:0] ibus_rdata_in,
  output logic [DATA_W-1:0] inst_out,
  output logic [ADDR_W-1:0] inst_addr_out,
  output logic              inst_valid_out
);

  typedef enum logic [1:0] {ISSUE, WAIT_GNT, WAIT_DATA} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic              discard_q;
  logic              skid_valid_q;
  logic [DATA_W-1:0] skid_data_q;
  logic [ADDR_W-1:0] skid_addr_q;
  logic [DATA_W-1:0] inst_q;
  logic [ADDR_W-1:0] inst_addr_q;
  logic              inst_valid_q;

  logic req;
  logic issue_ok;
  logic rsp_take;
  logic deliver;

  // A new fetch only starts when decode can eventually take it and nothing is parked.
  assign issue_ok = rst && !hold_flag_in && !skid_valid_q && !jump_flag_in;

  always_comb begin
    req     = 1'b0;
    state_d = state_q;
    case (state_q)
      ISSUE: begin
        req = issue_ok;
        if (req) state_d = ibus_gnt_in ? WAIT_DATA : WAIT_GNT;
      end
      WAIT_GNT: begin
        // An un-granted request must stay up even across a jump.
        req = rst;
        if (ibus_gnt_in) state_d = WAIT_DATA;
      end
      WAIT_DATA: begin
        if (ibus_rvalid_in) state_d = ISSUE;
      end
      default: state_d = ISSUE;
    endcase
  end

  assign rsp_take = (state_q == WAIT_DATA) && ibus_rvalid_in;
  assign deliver  = rsp_take && !discard_q && !jump_flag_in;

  assign ibus_req_out   = req;
  assign ibus_addr_out  = (state_q == ISSUE && req) ? pc_in : addr_q;
  assign hold_req_out   = !(state_q == ISSUE && req && ibus_gnt_in);
  assign inst_out       = inst_q;
  assign inst_addr_out  = inst_addr_q;
  assign inst_valid_out = inst_valid_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= ISSUE;
      addr_q       <= '0;
      discard_q    <= 1'b0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
      skid_addr_q  <= '0;
      inst_q       <= NOP_INST;
      inst_addr_q  <= '0;
      inst_valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == ISSUE && req) addr_q <= pc_in;

      // The response of a request caught by a jump is swallowed, then discard drops.
      if (rsp_take)                                discard_q <= 1'b0;
      else if (jump_flag_in && state_q != ISSUE)   discard_q <= 1'b1;

      if (jump_flag_in) begin
        skid_valid_q <= 1'b0;
        inst_q       <= NOP_INST;
        inst_valid_q <= 1'b0;
      end else if (hold_flag_in) begin
        if (deliver) begin
          skid_valid_q <= 1'b1;
          skid_data_q  <= ibus_rdata_in;
          skid_addr_q  <= addr_q;
        end
      end else if (skid_valid_q) begin
        inst_q       <= skid_data_q;
        inst_addr_q  <= skid_addr_q;
        inst_valid_q <= 1'b1;
        skid_valid_q <= 1'b0;
      end else if (deliver) begin
        inst_q       <= ibus_rdata_in;
        inst_addr_q  <= addr_q;
        inst_valid_q <= 1'b1;
      end else begin
        inst_q       <= NOP_INST;
        inst_valid_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_if_fetch.sv
// Bench for if_fetch: directed scenarios then random hold/jump/reset/bus timing,
// checked against a transaction-level model of the fetch stream.
module tb_if_fetch;
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] KEY = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] pc_in = '0;
  logic        jump_flag_in = 1'b0, hold_flag_in = 1'b0;
  logic        hold_req_out, ibus_req_out;
  logic [31:0] ibus_addr_out;
  logic        ibus_gnt_in = 1'b0, ibus_rvalid_in = 1'b0;
  logic [31:0] ibus_rdata_in = '0;
  logic [31:0] inst_out, inst_addr_out;
  logic        inst_valid_out;

  int n_cmp = 0, n_err = 0;

  always #5 clk = ~clk;

  if_fetch dut (
    .clk(clk), .rst(rst), .pc_in(pc_in), .jump_flag_in(jump_flag_in),
    .hold_flag_in(hold_flag_in), .hold_req_out(hold_req_out),
    .ibus_req_out(ibus_req_out), .ibus_addr_out(ibus_addr_out),
    .ibus_gnt_in(ibus_gnt_in), .ibus_rvalid_in(ibus_rvalid_in),
    .ibus_rdata_in(ibus_rdata_in), .inst_out(inst_out),
    .inst_addr_out(inst_addr_out), .inst_valid_out(inst_valid_out)
  );

  // Reference model: PC source, bus slave, and the ordered list of fetched
  // words that decode still has to see.
  logic [31:0] pc_m = '0;
  logic [31:0] exp_q[$];
  logic [31:0] seen_q[$];
  bit          wt = 0, wt_live = 0;
  logic [31:0] wt_addr = '0;
  int          gnt_cnt = 0;
  bit          os = 0, os_live = 0;
  logic [31:0] os_addr = '0;
  int          rv_cnt = 0;
  int          gdly = 0, rdly = 0, stray_pct = 0;
  int          run = 0, last_run = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: drive, check combinational outputs, clock, update model, check registers.
  task automatic cyc(input bit h, input bit j, input logic [31:0] tgt);
    bit          rv_real, exp_req, g, r, hr, rs;
    logic [31:0] p_inst, p_iaddr, pop;
    logic        p_valid;
    hold_flag_in = h;
    jump_flag_in = j;
    pc_in        = pc_m;
    rv_real      = os && rv_cnt == 0;
    ibus_rvalid_in = 1'b0;
    ibus_rdata_in  = $urandom;
    if (rv_real) begin
      ibus_rvalid_in = 1'b1;
      ibus_rdata_in  = os_addr ^ KEY;
    end else if (!os && $urandom_range(0, 99) < stray_pct) begin
      ibus_rvalid_in = 1'b1;
    end
    ibus_gnt_in = 1'b0;
    #1;
    exp_req = rst && (wt || (!os && !h && !j && exp_q.size() == 0));
    chk("req", ibus_req_out, exp_req);
    if (ibus_req_out && exp_req) chk("bus_addr", ibus_addr_out, wt ? wt_addr : pc_m);
    if (ibus_req_out && !wt) gnt_cnt = (gdly < 0) ? $urandom_range(0, 3) : gdly;
    g = ibus_req_out && gnt_cnt == 0;
    ibus_gnt_in = g;
    #1;
    chk("hold_req", hold_req_out, !(g && !wt && !os));
    r = ibus_req_out; hr = hold_req_out; rs = rst;
    p_inst = inst_out; p_iaddr = inst_addr_out; p_valid = inst_valid_out;
    @(posedge clk);
    if (!rs) begin
      exp_q.delete(); wt = 0; os = 0; run = 0;
    end else begin
      if (rv_real) begin
        if (os_live && !j) exp_q.push_back(os_addr);
        os = 0;
      end else if (os) rv_cnt--;
      if (r) run++; else run = 0;
      if (r && g) begin
        os = 1;
        os_addr = wt ? wt_addr : pc_m;
        os_live = wt ? wt_live : 1'b1;
        rv_cnt  = (rdly < 0) ? $urandom_range(0, 2) : rdly;
        wt = 0;
        last_run = run; run = 0;
      end else if (r) begin
        if (!wt) begin wt = 1; wt_addr = pc_m; wt_live = 1; end
        gnt_cnt--;
      end
      if (j) begin exp_q.delete(); os_live = 0; wt_live = 0; end
    end
    if (j) pc_m = tgt;
    else if (!hr) pc_m += 4;
    #1;
    if (!rs) begin
      chk("rst_valid", inst_valid_out, 0);
      chk("rst_inst", inst_out, NOP);
      chk("rst_iaddr", inst_addr_out, 0);
      chk("rst_bus_addr", ibus_addr_out, 0);
    end else begin
      if (!inst_valid_out) chk("nop_when_invalid", inst_out, NOP);
      if (j) begin
        chk("jump_valid", inst_valid_out, 0);
      end else if (h) begin
        chk("frozen_inst", inst_out, p_inst);
        chk("frozen_iaddr", inst_addr_out, p_iaddr);
        chk("frozen_valid", inst_valid_out, p_valid);
      end else begin
        if (inst_valid_out) begin
          chk("pending", exp_q.size() > 0, 1);
          if (exp_q.size() > 0) begin
            pop = exp_q.pop_front();
            chk("inst_addr", inst_addr_out, pop);
            chk("inst_data", inst_out, pop ^ KEY);
            seen_q.push_back(inst_addr_out);
          end
        end
        chk("undelivered", exp_q.size(), 0);
      end
    end
  endtask

  initial begin
    logic [31:0] pc_save;
    int          n0;
    @(posedge clk); #1;
    // reset held
    rst = 1'b0;
    repeat (3) cyc(0, 0, 0);
    // zero-wait bus: pc 0,4,8 every second cycle
    rst = 1'b1; gdly = 0; rdly = 0;
    repeat (6) cyc(0, 0, 0);
    chk("zw_count", seen_q.size(), 3);
    if (seen_q.size() == 3) begin
      chk("zw_a0", seen_q[0], 32'h0);
      chk("zw_a1", seen_q[1], 32'h4);
      chk("zw_a2", seen_q[2], 32'h8);
    end
    // gnt delayed three cycles at 0x10
    cyc(0, 1, 32'h10);
    gdly = 3;
    repeat (5) cyc(0, 0, 0);
    chk("gnt_wait_run", last_run, 4);
    chk("gnt_wait_addr", seen_q[$], 32'h10);
    gdly = 0;
    // hold while response outstanding for 0x20
    cyc(0, 1, 32'h20);
    rdly = 2;
    cyc(0, 0, 0);
    repeat (4) cyc(1, 0, 0);
    cyc(0, 0, 0);
    chk("skid_release", seen_q[$], 32'h20);
    cyc(0, 0, 0);
    // jump to 0x100 during WAIT_DATA of 0x8
    cyc(0, 1, 32'h8);
    cyc(0, 0, 0);
    n0 = seen_q.size();
    rdly = 0;
    cyc(0, 1, 32'h100);
    repeat (6) cyc(0, 0, 0);
    chk("jump_new_count", seen_q.size() - n0 > 0, 1);
    chk("jump_first", seen_q[n0], 32'h100);
    // jump beats hold with skid full
    cyc(0, 0, 0);
    cyc(0, 0, 0);
    cyc(0, 1, 32'h200);
    cyc(0, 0, 0);
    cyc(1, 0, 0);
    cyc(1, 1, 32'h300);
    chk("jhs_valid", inst_valid_out, 0);
    chk("jhs_inst", inst_out, NOP);
    // jump together with rvalid under hold
    cyc(0, 0, 0);
    cyc(1, 1, 32'h400);
    chk("jrv_valid", inst_valid_out, 0);
    chk("jrv_inst", inst_out, NOP);
    // reset in WAIT_GNT, then a late rvalid
    gdly = 5;
    cyc(0, 0, 0);
    cyc(0, 0, 0);
    rst = 1'b0;
    cyc(0, 0, 0);
    cyc(0, 0, 0);
    rst = 1'b1; stray_pct = 100;
    cyc(1, 0, 0);
    stray_pct = 0; gdly = 0;
    pc_save = pc_m;
    repeat (3) cyc(0, 0, 0);
    chk("restart_addr", seen_q[$], pc_save);
    // random traffic
    gdly = -1; rdly = -1; stray_pct = 10;
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 199) != 0);
      cyc($urandom_range(0, 3) == 0, $urandom_range(0, 24) == 0,
          {20'h0, 10'($urandom_range(0, 1023)), 2'b00});
    end
    rst = 1'b1;
    chk("random_progress", seen_q.size() > 200, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
